write_trace_buffer: RTL and testbench
=====================================

WRITE_TRACE_BUFFER -- requirements
Module: write_trace_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO entries; legal values are powers of two from 4 to 256.
REQ-002 SHALL have parameter CW, default 5 (= log2(DEPTH)+1), Count width.
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-005 SHALL have port EnableRegisterWrite, input, 1, core commits a register write this cycle.
REQ-006 SHALL have port RegisterToWrite, input, 4, destination register index.
REQ-007 SHALL have port DataToWriteIntoRegister, input, 32, register write data.
REQ-008 SHALL have port EnableMemoryWrite, input, 1, core commits a memory write this cycle.
REQ-009 SHALL have port AddressToWriteIntoMemory, input, 32, memory write address.
REQ-010 SHALL have port DataToWriteIntoMemory, input, 32, memory write data.
REQ-011 SHALL have port TraceValid, output, 1, head entry available.
REQ-012 SHALL have port TraceReady, input, 1, consumer accepts the head entry.
REQ-013 SHALL have port TraceKind, output, 1, head entry type: 0 = register, 1 = memory.
REQ-014 SHALL have port TraceTag, output, 32, head entry target: zero-extended register index or memory address.
REQ-015 SHALL have port TraceData, output, 32, head entry data.
REQ-016 SHALL have port Count, output, CW, number of occupied entries.
REQ-017 SHALL have port Overflow, output, 1, sticky flag set when any event is dropped.
REQ-018 SHALL have port DroppedCount, output, 16, number of dropped events (see Configuration).

Function
REQ-019 SHALL be a first-word-fall-through FIFO of {kind, tag, data} entries; TraceValid = (Count != 0).
REQ-020 SHALL pop exactly one entry on each rising edge where TraceValid && TraceReady; TraceReady while empty has no effect.
REQ-021 SHALL push an event sampled at edge N so that it is visible on the outputs immediately after edge N (one-cycle latency when empty).
REQ-022 SHALL compute free space before any same-cycle pop; a pop does not create room for a push in the same cycle.
REQ-023 SHALL, for a single event with free >= 1, push that event.
REQ-024 SHALL, when both enables are high with free >= 2, push two entries in one cycle, register entry first, memory entry second.
REQ-025 SHALL, when both enables are high with free == 1, push the register entry and drop the memory entry.
REQ-026 SHALL, with free == 0, drop all events presented that cycle.
REQ-027 SHALL update Count by pushes minus pop each cycle (range 0..DEPTH); read/write pointers wrap modulo DEPTH without disturbing order.
REQ-028 SHALL set Overflow on the edge of any drop and hold it until reset.
REQ-029 SHALL hold TraceKind/TraceTag/TraceData stable while TraceValid is high and no pop occurs.

Reset
REQ-030 SHALL, on reset assertion (including mid-operation), clear immediately: Count=0, TraceValid=0, Overflow=0, DroppedCount=0, pointers=0; TraceKind/TraceTag/TraceData read 0.
REQ-031 SHALL ignore all events sampled on edges where reset is high; capture resumes on the first edge after deassertion.

Configuration
REQ-032 SHALL, with macro TRACE_DROP_COUNT_EN defined, increment DroppedCount by the number of events dropped each cycle (0, 1 or 2), saturating at 0xFFFF.
REQ-033 SHALL, without TRACE_DROP_COUNT_EN, drive DroppedCount constant 0 and include no counter logic; Overflow behaves identically in both builds.

Verification
REQ-034 SHALL cover: single register write R3=0x0000002A, TraceReady=0 -> next cycle TraceValid=1, Kind=0, Tag=3, Data=0x2A, Count=1.
REQ-035 SHALL cover: simultaneous R5=0x11 and Mem[0x100]=0x22 while empty -> Count=2; pops return (0,5,0x11) then (1,0x100,0x22).
REQ-036 SHALL cover: fill to 15 entries, then a simultaneous event -> register pushed, Count=16, Overflow=1, DroppedCount=1 (0 without macro).
REQ-037 SHALL cover: full FIFO with TraceReady=1 and a single new event -> event dropped, Count=15, DroppedCount increments.
REQ-038 SHALL cover: 40 sequential events with TraceReady=1 continuously -> all 40 received in order across pointer wrap, Overflow=0.
REQ-039 SHALL cover: assert reset with Count=7 -> Count=0, TraceValid=0, Overflow=0 before the next clock edge.

Source files
------------

// File: rtl/write_trace_buffer.sv
// Commit trace FIFO: captures register/memory writes (up to two per cycle) for a consumer.
// Optional macro TRACE_DROP_COUNT_EN enables the saturating DroppedCount counter.
module write_trace_buffer #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CW    = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          EnableRegisterWrite,
  input  logic [3:0]    RegisterToWrite,
  input  logic [31:0]   DataToWriteIntoRegister,
  input  logic          EnableMemoryWrite,
  input  logic [31:0]   AddressToWriteIntoMemory,
  input  logic [31:0]   DataToWriteIntoMemory,
  output logic          TraceValid,
  input  logic          TraceReady,
  output logic          TraceKind,
  output logic [31:0]   TraceTag,
  output logic [31:0]   TraceData,
  output logic [CW-1:0] Count,
  output logic          Overflow,
  output logic [15:0]   DroppedCount
);

  localparam int unsigned PW = $clog2(DEPTH);

  // Entry layout: {kind, tag[31:0], data[31:0]}
  logic [64:0]   mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;

  logic [CW-1:0] free;
  logic          push_reg, push_mem, pop, drop_any;
  logic [1:0]    n_push;
  logic [64:0]   reg_entry, mem_entry, entry_a;
  logic [64:0]   head;

  always_comb begin
    reg_entry = {1'b0, 28'd0, RegisterToWrite, DataToWriteIntoRegister};
    mem_entry = {1'b1, AddressToWriteIntoMemory, DataToWriteIntoMemory};
    // Room is judged on the pre-pop occupancy.
    free      = CW'(DEPTH) - count_q;
    push_reg  = EnableRegisterWrite && (free != '0);
    push_mem  = EnableMemoryWrite &&
                (EnableRegisterWrite ? (free >= CW'(2)) : (free != '0));
    drop_any  = (EnableRegisterWrite && !push_reg) || (EnableMemoryWrite && !push_mem);
    n_push    = {1'b0, push_reg} + {1'b0, push_mem};
    entry_a   = push_reg ? reg_entry : mem_entry;
    pop       = (count_q != '0) && TraceReady;
    count_d   = count_q + CW'(n_push) - CW'(pop);
    wr_ptr_d  = wr_ptr_q + PW'(n_push);
    rd_ptr_d  = rd_ptr_q + PW'(pop);
    overflow_d = overflow_q || drop_any;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is not reset; outputs are masked while empty instead.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (n_push != 2'd0)
        mem_q[wr_ptr_q] <= entry_a;
      if (n_push == 2'd2)
        mem_q[wr_ptr_q + PW'(1)] <= mem_entry;
    end
  end

`ifdef TRACE_DROP_COUNT_EN
  logic [15:0] dropped_q, dropped_d;
  logic [1:0]  n_drop;
  logic [16:0] dropped_sum;

  always_comb begin
    n_drop      = ({1'b0, EnableRegisterWrite} + {1'b0, EnableMemoryWrite}) - n_push;
    dropped_sum = {1'b0, dropped_q} + 17'(n_drop);
    dropped_d   = dropped_sum[16] ? '1 : dropped_sum[15:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) dropped_q <= '0;
    else       dropped_q <= dropped_d;
  end

  assign DroppedCount = dropped_q;
`else
  assign DroppedCount = '0;
`endif

  always_comb begin
    head       = mem_q[rd_ptr_q];
    TraceValid = (count_q != '0);
    TraceKind  = TraceValid ? head[64]    : 1'b0;
    TraceTag   = TraceValid ? head[63:32] : '0;
    TraceData  = TraceValid ? head[31:0]  : '0;
    Count      = count_q;
    Overflow   = overflow_q;
  end

endmodule

// File: tb/tb_write_trace_buffer.sv
// Directed self-checking bench for write_trace_buffer (default DEPTH=16).
module tb_write_trace_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        EnableRegisterWrite;
  logic [3:0]  RegisterToWrite;
  logic [31:0] DataToWriteIntoRegister;
  logic        EnableMemoryWrite;
  logic [31:0] AddressToWriteIntoMemory;
  logic [31:0] DataToWriteIntoMemory;
  logic        TraceValid;
  logic        TraceReady;
  logic        TraceKind;
  logic [31:0] TraceTag;
  logic [31:0] TraceData;
  logic [4:0]  Count;
  logic        Overflow;
  logic [15:0] DroppedCount;

  int unsigned errors = 0;
  int unsigned checks = 0;

  write_trace_buffer #(.DEPTH(16), .CW(5)) dut (
    .clk                      (clk),
    .reset                    (reset),
    .EnableRegisterWrite      (EnableRegisterWrite),
    .RegisterToWrite          (RegisterToWrite),
    .DataToWriteIntoRegister  (DataToWriteIntoRegister),
    .EnableMemoryWrite        (EnableMemoryWrite),
    .AddressToWriteIntoMemory (AddressToWriteIntoMemory),
    .DataToWriteIntoMemory    (DataToWriteIntoMemory),
    .TraceValid               (TraceValid),
    .TraceReady               (TraceReady),
    .TraceKind                (TraceKind),
    .TraceTag                 (TraceTag),
    .TraceData                (TraceData),
    .Count                    (Count),
    .Overflow                 (Overflow),
    .DroppedCount             (DroppedCount)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic re, input logic [3:0] r, input logic [31:0] rd,
                       input logic me, input logic [31:0] a, input logic [31:0] md);
    EnableRegisterWrite      = re;
    RegisterToWrite          = r;
    DataToWriteIntoRegister  = rd;
    EnableMemoryWrite        = me;
    AddressToWriteIntoMemory = a;
    DataToWriteIntoMemory    = md;
  endtask

  task automatic idle();
    drive(1'b0, 4'h0, 32'h0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic head(input string tag, input logic k, input logic [31:0] t, input logic [31:0] d);
    check({tag, "_valid"}, 32'(TraceValid), 32'd1);
    check({tag, "_kind"},  32'(TraceKind),  32'(k));
    check({tag, "_tag"},   TraceTag, t);
    check({tag, "_data"},  TraceData, d);
  endtask

  localparam logic [15:0] DROP1 =
`ifdef TRACE_DROP_COUNT_EN
    16'd1;
`else
    16'd0;
`endif
  localparam logic [15:0] DROP2 =
`ifdef TRACE_DROP_COUNT_EN
    16'd2;
`else
    16'd0;
`endif

  initial begin
    reset = 1'b1;
    TraceReady = 1'b0;
    idle();
    step();
    step();
    check("rst_count",    32'(Count), 32'd0);
    check("rst_valid",    32'(TraceValid), 32'd0);
    check("rst_overflow", 32'(Overflow), 32'd0);
    check("rst_dropped",  32'(DroppedCount), 32'd0);
    check("rst_tag",      TraceTag, 32'd0);
    reset = 1'b0;

    // Single register write, consumer stalled
    drive(1'b1, 4'd3, 32'h2A, 1'b0, 32'h0, 32'h0);
    step();
    idle();
    head("r3", 1'b0, 32'd3, 32'h2A);
    check("r3_count", 32'(Count), 32'd1);
    step();
    head("r3_hold", 1'b0, 32'd3, 32'h2A);
    TraceReady = 1'b1;
    step();
    TraceReady = 1'b0;
    check("r3_popped", 32'(Count), 32'd0);

    // Simultaneous register and memory writes
    drive(1'b1, 4'd5, 32'h11, 1'b1, 32'h100, 32'h22);
    step();
    idle();
    check("dual_count", 32'(Count), 32'd2);
    head("dual_first", 1'b0, 32'd5, 32'h11);
    TraceReady = 1'b1;
    step();
    head("dual_second", 1'b1, 32'h100, 32'h22);
    check("dual_count1", 32'(Count), 32'd1);
    step();
    TraceReady = 1'b0;
    check("dual_empty", 32'(TraceValid), 32'd0);

    // Fill to 15, then a dual event: register kept, memory dropped
    for (int i = 0; i < 15; i++) begin
      drive(1'b1, 4'(i), 32'h100 + 32'(i), 1'b0, 32'h0, 32'h0);
      step();
    end
    check("fill_count15", 32'(Count), 32'd15);
    check("fill_no_ovf", 32'(Overflow), 32'd0);
    drive(1'b1, 4'hF, 32'hAA, 1'b1, 32'h200, 32'hBB);
    step();
    idle();
    check("full_count", 32'(Count), 32'd16);
    check("full_ovf", 32'(Overflow), 32'd1);
    check("full_dropped", 32'(DroppedCount), 32'(DROP1));
    head("full_head", 1'b0, 32'd0, 32'h100);

    // Full with pop and a new event: pop frees no room this cycle
    TraceReady = 1'b1;
    drive(1'b0, 4'h0, 32'h0, 1'b1, 32'h300, 32'hCC);
    step();
    idle();
    check("fullpop_count", 32'(Count), 32'd15);
    check("fullpop_dropped", 32'(DroppedCount), 32'(DROP2));
    for (int i = 1; i < 15; i++) begin
      check("drain_data", TraceData, 32'h100 + 32'(i));
      check("drain_tag", TraceTag, 32'(i));
      step();
    end
    head("drain_last", 1'b0, 32'hF, 32'hAA);
    step();
    TraceReady = 1'b0;
    check("drain_empty", 32'(Count), 32'd0);
    check("ovf_sticky", 32'(Overflow), 32'd1);

    // Asynchronous reset mid-operation with 7 entries
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 4'(i), 32'h500 + 32'(i), 1'b0, 32'h0, 32'h0);
      step();
    end
    idle();
    check("pre_rst_count", 32'(Count), 32'd7);
    #2 reset = 1'b1;
    #1;
    check("arst_count", 32'(Count), 32'd0);
    check("arst_valid", 32'(TraceValid), 32'd0);
    check("arst_ovf", 32'(Overflow), 32'd0);
    check("arst_dropped", 32'(DroppedCount), 32'd0);
    check("arst_data", TraceData, 32'd0);
    drive(1'b1, 4'd9, 32'h99, 1'b1, 32'h900, 32'h99);
    step();
    reset = 1'b0;
    idle();
    step();
    check("rst_ignored", 32'(Count), 32'd0);

    // 40 back-to-back events with a streaming consumer, across pointer wrap
    TraceReady = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (k % 2 == 0)
        drive(1'b1, 4'(k % 16), 32'h1000 + 32'(k), 1'b0, 32'h0, 32'h0);
      else
        drive(1'b0, 4'h0, 32'h0, 1'b1, 32'h2000 + 32'(k * 4), 32'h1000 + 32'(k));
      step();
      check("stream_kind", 32'(TraceKind), 32'(k % 2));
      check("stream_tag", TraceTag, (k % 2 == 0) ? 32'(k % 16) : 32'h2000 + 32'(k * 4));
      check("stream_data", TraceData, 32'h1000 + 32'(k));
      check("stream_count", 32'(Count), 32'd1);
    end
    idle();
    step();
    TraceReady = 1'b0;
    check("stream_empty", 32'(Count), 32'd0);
    check("stream_no_ovf", 32'(Overflow), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
